// File: rtl/sqr_wav_pkg.sv
// Shared definitions for the square-wave generator/measurement pair.
// Holds the measurement FSM encoding and the default prescaler ratio.
package sqr_wav_pkg;

  typedef enum logic [1:0] {
    WAIT_RISE = 2'd0,
    HIGH      = 2'd1,
    LOW       = 2'd2
  } meas_state_t;

  localparam int unsigned DEFAULT_TICK_DIV = 5;

endpackage

// File: rtl/sqr_wav_meas_sync_edge_det.sv
// Two-flop synchroniser plus delay flop for an asynchronous level input.
// Produces the synchronised level and single-cycle rise/fall pulses.
module sync_edge_det (
  input  logic clk,
  input  logic reset,
  input  logic din,
  output logic lvl,
  output logic rise,
  output logic fall
);

  logic s1, s2, s3;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
      s3 <= 1'b0;
    end else begin
      s1 <= din;
      s2 <= s1;
      s3 <= s2;
    end
  end

  assign lvl  = s2;
  assign rise = s2 & ~s3;
  assign fall = ~s2 & s3;

endmodule

// File: rtl/sqr_wav_meas.sv
// Measures high and low durations of an asynchronous square wave in TICK_DIV-clock
// units and publishes each complete period with a one-cycle valid strobe.
module sqr_wav_meas
  import sqr_wav_pkg::*;
#(
  parameter int unsigned N        = 4,
  parameter int unsigned TICK_DIV = DEFAULT_TICK_DIV
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         sqr_wav_i,
  input  logic         clr,
  output logic [N-1:0] m_meas,
  output logic [N-1:0] n_meas,
  output logic         meas_valid,
  output logic         meas_sat
);

  localparam int unsigned    PW      = $clog2(TICK_DIV);
  localparam logic [PW-1:0]  PRE_MAX = PW'(TICK_DIV - 1);
  localparam logic [PW-1:0]  PRE_ONE = PW'(1);
  localparam logic [N-1:0]   CNT_MAX = '1;
  localparam logic [N-1:0]   CNT_ONE = N'(1);

  meas_state_t   state, state_next;
  logic          lvl, rise, fall, edge_cyc;
  logic [PW-1:0] pre;
  logic          tick;
  logic [N-1:0]  cnt;
  logic          sat_ph;
  logic          cnt_run;
  logic [N-1:0]  hi_hold;
  logic          hi_sat;
  logic          latch_hi, publish;

  sync_edge_det u_sync (
    .clk   (clk),
    .reset (reset),
    .din   (sqr_wav_i),
    .lvl   (lvl),
    .rise  (rise),
    .fall  (fall)
  );

  assign edge_cyc = rise | fall;
  assign tick     = (pre == PRE_MAX);

  // Edge cycle counts as the first clock of the new phase, hence the load of 1.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pre <= '0;
    end else if (clr) begin
      pre <= '0;
    end else if (edge_cyc) begin
      pre <= PRE_ONE;
    end else if (tick) begin
      pre <= '0;
    end else begin
      pre <= pre + PRE_ONE;
    end
  end

  assign cnt_run = ((state == HIGH) & lvl) | ((state == LOW) & ~lvl);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt    <= '0;
      sat_ph <= 1'b0;
    end else if (clr || edge_cyc) begin
      cnt    <= '0;
      sat_ph <= 1'b0;
    end else if (tick && cnt_run) begin
      if (cnt == CNT_MAX) begin
        sat_ph <= 1'b1;
      end else begin
        cnt <= cnt + CNT_ONE;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= WAIT_RISE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    latch_hi   = 1'b0;
    publish    = 1'b0;
    if (clr) begin
      state_next = WAIT_RISE;
    end else begin
      unique case (state)
        WAIT_RISE: begin
          if (rise) state_next = HIGH;
        end
        HIGH: begin
          if (fall) begin
            latch_hi   = 1'b1;
            state_next = LOW;
          end
        end
        LOW: begin
          if (rise) begin
            publish    = 1'b1;
            state_next = HIGH;
          end
        end
        default: state_next = WAIT_RISE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hi_hold    <= '0;
      hi_sat     <= 1'b0;
      m_meas     <= '0;
      n_meas     <= '0;
      meas_valid <= 1'b0;
      meas_sat   <= 1'b0;
    end else if (clr) begin
      hi_hold    <= '0;
      hi_sat     <= 1'b0;
      m_meas     <= '0;
      n_meas     <= '0;
      meas_valid <= 1'b0;
      meas_sat   <= 1'b0;
    end else begin
      meas_valid <= publish;
      if (latch_hi) begin
        hi_hold <= cnt;
        hi_sat  <= sat_ph;
      end
      if (publish) begin
        m_meas   <= hi_hold;
        n_meas   <= cnt;
        meas_sat <= hi_sat | sat_ph;
      end
    end
  end

endmodule
